// File: rtl/pipe_stage_chain_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain_if
//   Handshake bundle for pipe_stage_chain: the producer-side valid/ready/data
//   triple and the consumer-side valid/ready/data triple.
//
//   Parameter: WIDTH - payload bits.
//   Signals:
//     in_valid  producer offers in_data
//     in_data   producer payload
//     in_ready  chain accepts this cycle
//     out_valid chain presents a deliverable item
//     out_data  payload of the last stage
//     out_ready consumer accepts
//   Modports:
//     master - the environment (drives in_*, out_ready)
//     slave  - the chain itself (drives in_ready, out_valid, out_data)
// -----------------------------------------------------------------------------
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//   Elastic pipeline register chain with per-stage valid bits, valid/ready
//   handshake, bubble collapse, global stall, per-stage flush and a global
//   clock enable. Stage 0 is the input side, stage STAGES-1 drives out_data.
//
//   Parameters:
//     WIDTH  - payload bits per stage
//     STAGES - number of register stages (2..16)
//     CW     - occupancy width, derived
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high reset
//     clkEnable  global enable, low freezes the chain
//     stall      global hold, freezes all stages
//     flush      bit i kills the item held in stage i
//     bus        handshake bundle (slave side)
//     occupancy  number of valid stages (registered)
//     stall_cnt  cycles stalled while non-empty (perf counter)
//     bubble_cnt cycles the consumer was ready but nothing was offered
//
//   Optional feature: define PIPE_CHAIN_PERF_EN to build the saturating
//   16-bit performance counters; otherwise both counter ports read 0.
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 4,
  localparam int CW     = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clkEnable,
  input  logic                 stall,
  input  logic [STAGES-1:0]    flush,
  pipe_stage_chain_if.slave    bus,
  output logic [CW-1:0]        occupancy,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          bubble_cnt
);

  logic              en;
  logic              goIn;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] vNext;
  logic [STAGES-1:0] m;
  logic [STAGES-1:0] go;
  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] goPrev;
  logic [WIDTH-1:0]  d [STAGES];

  assign en = clkEnable & ~stall;
  // An item survives the cycle only if its stage is not being flushed.
  assign m  = v & ~flush;

  // Readiness ripples backwards from the consumer: a stage can move on when
  // the stage after it is empty or emptying, which is what closes bubbles.
  always_comb begin
    // NOTE: every bit gets a default before the loop so no latch is inferred.
    go  = '0;
    acc = '0;
    go[STAGES-1]  = en & m[STAGES-1] & bus.out_ready;
    acc[STAGES-1] = ~flush[STAGES-1] & (~m[STAGES-1] | go[STAGES-1]);
    for (int i = STAGES - 2; i >= 0; i--) begin
      go[i]  = en & m[i] & acc[i+1];
      acc[i] = ~flush[i] & (~m[i] | go[i]);
    end
  end

  assign bus.in_ready  = en & acc[0];
  assign bus.out_valid = en & m[STAGES-1];
  assign bus.out_data  = d[STAGES-1];

  assign goIn   = bus.in_valid & bus.in_ready;
  // goPrev[i]: stage i loads from its upstream neighbour this cycle.
  assign goPrev = {go[STAGES-2:0], goIn};

  // With en low every go is 0, so this collapses to v & ~flush: the flush
  // still kills items while the chain is otherwise frozen.
  assign vNext = (m & ~go) | goPrev;

  // NOTE: the payload array is reset too, so out_data reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every stage
      // samples its neighbour's pre-edge value.
      v         <= vNext;
      occupancy <= CW'($countones(vNext));
      if (goPrev[0]) d[0] <= bus.in_data;
      for (int i = 1; i < STAGES; i++) begin
        if (goPrev[i]) d[i] <= d[i-1];
      end
    end
  end

`ifdef PIPE_CHAIN_PERF_EN
  logic stallHit;
  logic bubbleHit;

  assign stallHit  = clkEnable & stall & (occupancy != '0);
  assign bubbleHit = en & bus.out_ready & ~bus.out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stallHit && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (bubbleHit && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
//   Directed bench for pipe_stage_chain (WIDTH=32, STAGES=4). Inputs change
//   1 time unit after each rising edge; outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int CW     = $clog2(STAGES + 1);

  logic              clk;
  logic              reset;
  logic              clkEnable;
  logic              stall;
  logic [STAGES-1:0] flush;
  logic [CW-1:0]     occupancy;
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;

  int nChecks = 0;
  int nFails  = 0;

  pipe_stage_chain_if #(.WIDTH(WIDTH)) bus ();

  pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .clkEnable  (clkEnable),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    stall         = 1'b0;
    flush         = '0;
    clkEnable     = 1'b1;
  endtask

  // Occupancy seen in cycle j of an 8-word back-to-back stream with the
  // consumer always ready (first accept at the end of cycle 0).
  function automatic int streamOcc(int j);
    if (j <= 3) return j;
    if (j <= 8) return 4;
    if (j <= 12) return 12 - j;
    return 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ptr;
    int enCount;
    int acceptEn;
    int deliverEn;

    reset = 1'b1;
    idle();
    #2;
    check("rst occupancy", occupancy, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_data", bus.out_data, 0);
    check("rst in_ready", bus.in_ready, 1);
    check("rst stall_cnt", stall_cnt, 0);
    check("rst bubble_cnt", bubble_cnt, 0);
    flush = 4'b0001;
    #1;
    check("rst in_ready flush0", bus.in_ready, 0);
    flush = '0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Streaming at full rate.
    for (int j = 0; j < 13; j++) begin
      idle();
      bus.out_ready = 1'b1;
      bus.in_valid  = (j < 8);
      bus.in_data   = 32'(j + 1);
      #1;
      check($sformatf("t1 in_ready c%0d", j), bus.in_ready, 1);
      check($sformatf("t1 out_valid c%0d", j), bus.out_valid, 32'(j >= 4 && j <= 11));
      if (j >= 4 && j <= 11) check($sformatf("t1 out_data c%0d", j), bus.out_data, 32'(j - 3));
      check($sformatf("t1 occupancy c%0d", j), occupancy, 32'(streamOcc(j)));
      tick();
    end

    // Backpressure: fill, block, then drain six words.
    for (int j = 0; j < 13; j++) begin
      idle();
      bus.out_ready = (j >= 6);
      bus.in_valid  = (j <= 7);
      bus.in_data   = (j < 4) ? 32'h11 + 32'(j) : ((j <= 6) ? 32'h15 : 32'h16);
      #1;
      check($sformatf("t2 in_ready c%0d", j), bus.in_ready, 32'(j < 4 || j >= 6));
      check($sformatf("t2 out_valid c%0d", j), bus.out_valid, 32'(j >= 4 && j <= 11));
      if (j >= 4 && j <= 11)
        check($sformatf("t2 out_data c%0d", j), bus.out_data, (j <= 6) ? 32'h11 : 32'h11 + 32'(j - 6));
      check($sformatf("t2 occupancy c%0d", j), occupancy,
            (j <= 3) ? 32'(j) : ((j <= 8) ? 32'd4 : 32'(12 - j)));
      tick();
    end

    // Bubble collapse: A, idle, idle, B against a blocked consumer.
    for (int j = 0; j < 10; j++) begin
      idle();
      bus.out_ready = (j >= 7);
      bus.in_valid  = (j == 0 || j == 3);
      bus.in_data   = (j == 0) ? 32'hA : 32'hB;
      #1;
      check($sformatf("t3 in_ready c%0d", j), bus.in_ready, 1);
      check($sformatf("t3 out_valid c%0d", j), bus.out_valid, 32'(j >= 4 && j <= 8));
      if (j >= 4 && j <= 8)
        check($sformatf("t3 out_data c%0d", j), bus.out_data, (j <= 7) ? 32'hA : 32'hB);
      case (j)
        0, 9:           check($sformatf("t3 occupancy c%0d", j), occupancy, 0);
        1, 2, 3, 8:     check($sformatf("t3 occupancy c%0d", j), occupancy, 1);
        default:        check($sformatf("t3 occupancy c%0d", j), occupancy, 2);
      endcase
      if (j == 7) check("t3 valid bits", dut.v, 4'b1100);
      tick();
    end

    // Flush stages 0 and 2 of a full chain; survivors drain in order.
    for (int j = 0; j < 9; j++) begin
      idle();
      bus.out_ready = (j >= 6);
      bus.in_valid  = (j < 4);
      bus.in_data   = 32'h41 + 32'(j);
      flush         = (j == 4) ? 4'b0101 : 4'b0000;
      #1;
      check($sformatf("t4 in_ready c%0d", j), bus.in_ready, 32'(j != 4));
      check($sformatf("t4 out_valid c%0d", j), bus.out_valid, 32'(j >= 4 && j <= 7));
      if (j >= 4 && j <= 7)
        check($sformatf("t4 out_data c%0d", j), bus.out_data, (j <= 6) ? 32'h41 : 32'h43);
      check($sformatf("t4 occupancy c%0d", j), occupancy,
            (j <= 3) ? 32'(j) : ((j == 4) ? 32'd4 : ((j <= 6) ? 32'd2 : ((j == 7) ? 32'd1 : 32'd0))));
      tick();
    end

    // Flush of the output stage: once while stalled, once with out_ready high.
    for (int j = 0; j < 8; j++) begin
      idle();
      bus.in_valid  = (j < 2);
      bus.in_data   = 32'h71 + 32'(j);
      bus.out_ready = (j == 4 || j == 6);
      stall         = (j == 4);
      flush         = (j == 4 || j == 6) ? 4'b1000 : 4'b0000;
      #1;
      check($sformatf("t4b in_ready c%0d", j), bus.in_ready, 32'(j != 4));
      check($sformatf("t4b out_valid c%0d", j), bus.out_valid, 0);
      check($sformatf("t4b occupancy c%0d", j), occupancy,
            (j <= 1) ? 32'(j) : ((j <= 4) ? 32'd2 : ((j <= 6) ? 32'd1 : 32'd0)));
      tick();
    end

    // clkEnable toggling every other cycle, 8 words, consumer always ready.
    ptr       = 0;
    enCount   = 0;
    acceptEn  = -1;
    deliverEn = -1;
    for (int j = 0; j < 26; j++) begin
      idle();
      clkEnable     = (j % 2 == 0);
      bus.out_ready = 1'b1;
      bus.in_valid  = (ptr < 8);
      bus.in_data   = 32'h51 + 32'(ptr);
      #1;
      check($sformatf("t5 in_ready c%0d", j), bus.in_ready, 32'(j % 2 == 0));
      check($sformatf("t5 out_valid c%0d", j), bus.out_valid,
            32'(j % 2 == 0 && j / 2 >= 4 && j / 2 <= 11));
      if (j % 2 == 0 && j / 2 >= 4 && j / 2 <= 11)
        check($sformatf("t5 out_data c%0d", j), bus.out_data, 32'h4D + 32'(j / 2));
      check($sformatf("t5 occupancy c%0d", j), occupancy, 32'(streamOcc((j + 1) / 2)));
      if (bus.in_valid && bus.in_ready && ptr == 0) acceptEn = enCount;
      if (bus.out_valid && bus.out_data == 32'h51 && deliverEn < 0) deliverEn = enCount;
      if (clkEnable) enCount++;
      if (bus.in_valid && j % 2 == 0) ptr++;
      tick();
    end
    check("t5 latency enabled cycles", 32'(deliverEn - acceptEn), 4);

    // Fresh reset, bubbles, stall with items in flight, then reset mid-stream.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int j = 0; j < 12; j++) begin
      idle();
      bus.out_ready = (j < 2);
      bus.in_valid  = (j >= 2 && j <= 4);
      bus.in_data   = 32'h61 + 32'(j - 2);
      stall         = (j >= 5 && j <= 9);
      #1;
      check($sformatf("t6 in_ready c%0d", j), bus.in_ready, 32'(j < 5 || j > 9));
      check($sformatf("t6 out_valid c%0d", j), bus.out_valid, 32'(j == 11));
      if (j == 11) check("t6 out_data c11", bus.out_data, 32'h61);
      check($sformatf("t6 occupancy c%0d", j), occupancy,
            (j <= 2) ? 32'd0 : ((j <= 4) ? 32'(j - 2) : 32'd3));
`ifdef PIPE_CHAIN_PERF_EN
      check($sformatf("t6 stall_cnt c%0d", j), stall_cnt,
            (j <= 5) ? 32'd0 : ((j >= 10) ? 32'd5 : 32'(j - 5)));
      check($sformatf("t6 bubble_cnt c%0d", j), bubble_cnt, (j <= 2) ? 32'(j) : 32'd2);
`else
      check($sformatf("t6 stall_cnt c%0d", j), stall_cnt, 0);
      check($sformatf("t6 bubble_cnt c%0d", j), bubble_cnt, 0);
`endif
      if (j < 11) tick();
    end
    #2;
    reset = 1'b1;
    #1;
    check("t6 reset occupancy", occupancy, 0);
    check("t6 reset out_valid", bus.out_valid, 0);
    check("t6 reset out_data", bus.out_data, 0);
    check("t6 reset stall_cnt", stall_cnt, 0);
    check("t6 reset bubble_cnt", bubble_cnt, 0);
    reset = 1'b0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
